// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole sequencer: state encoding,
// default sizing, LFSR polynomial and small position helpers.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_SHOW  = 3'd2,
        ST_COOL  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int         N_MOLES_DEF   = 4;
    localparam int         MAX_MISS_DEF  = 5;
    localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
    // Feedback taps for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3 of a left-shifting register)
    localparam logic [7:0] LFSR_TAPS     = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [3:0] mole_onehot(input logic [1:0] p);
        return 4'b0001 << p;
    endfunction

    // Never light the same hole twice in a row
    function automatic logic [1:0] pick_pos(input logic [1:0] r, input logic [1:0] prev);
        return (r == prev) ? r + 2'd1 : r;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a delay flop and registered rise/fall/any-edge
// pulses; each pulse lasts exactly one clk_in cycle.
module sync_edge (
    input  logic clk_in,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall,
    output logic any_edge
);

    logic sync_p0, sync_p1, dly_p2;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 1'b0;
            sync_p1  <= 1'b0;
            dly_p2   <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            any_edge <= 1'b0;
        end else begin
            sync_p0  <= async_in;
            sync_p1  <= sync_p0;
            dly_p2   <= sync_p1;
            rise     <= sync_p1 & ~dly_p2;
            fall     <= ~sync_p1 & dly_p2;
            any_edge <= sync_p1 ^ dly_p2;
        end
    end

endmodule

// File: rtl/mole_sequencer.sv
// Whack-a-mole game sequencer: lights one mole per slow_clk beat, scores
// matching button presses, counts misses and ends the game after MAX_MISS.
module mole_sequencer
    import whack_pkg::*;
#(
    parameter int         N_MOLES   = N_MOLES_DEF,
    parameter int         MAX_MISS  = MAX_MISS_DEF,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic               clk_in,
    input  logic               rst_n,
    input  logic               slow_clk,
    input  logic               start,
    input  logic [N_MOLES-1:0] btn,
    output logic [N_MOLES-1:0] mole,
    output logic               hit,
    output logic               miss,
    output logic [7:0]         score,
    output logic               game_over
);

    localparam logic [8:0] MAX_MISS_W = 9'(MAX_MISS);

    state_t             state_q, state_d;
    logic               beat;
    logic [N_MOLES-1:0] press;
    logic [7:0]         lfsr;
    logic [1:0]         pos;
    logic [7:0]         miss_cnt;
    logic [8:0]         miss_cnt_inc;
    logic               hit_d, miss_d, pos_en, clear;

    logic               beat_rise_unused, beat_fall_unused;
    logic [N_MOLES-1:0] btn_fall_unused, btn_any_unused;

    sync_edge u_beat (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .async_in (slow_clk),
        .rise     (beat_rise_unused),
        .fall     (beat_fall_unused),
        .any_edge (beat)
    );

    for (genvar i = 0; i < N_MOLES; i++) begin : g_btn
        sync_edge u_btn (
            .clk_in   (clk_in),
            .rst_n    (rst_n),
            .async_in (btn[i]),
            .rise     (press[i]),
            .fall     (btn_fall_unused[i]),
            .any_edge (btn_any_unused[i])
        );
    end

    assign miss_cnt_inc = {1'b0, miss_cnt} + 9'd1;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        pos_en  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_ARMED;
                    clear   = 1'b1;
                end
            end
            ST_ARMED, ST_COOL: begin
                if (beat) begin
                    state_d = ST_SHOW;
                    pos_en  = 1'b1;
                end
            end
            ST_SHOW: begin
                if (press != '0) begin
                    if (press == mole_onehot(pos)) begin
                        hit_d = 1'b1;
                        // A beat landing with the correct press keeps the round going
                        if (beat) pos_en  = 1'b1;
                        else      state_d = ST_COOL;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = ST_COOL;
                    end
                end else if (beat) begin
                    miss_d = 1'b1;
                    pos_en = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The final miss ends the game regardless of where the round was heading
        if (miss_d && (miss_cnt_inc >= MAX_MISS_W)) begin
            state_d = ST_OVER;
            pos_en  = 1'b0;
        end
    end

    always_comb begin
        mole      = '0;
        game_over = 1'b0;
        case (state_q)
            ST_SHOW: mole = mole_onehot(pos);
            ST_OVER: begin
                mole      = '1;
                game_over = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            pos      <= 2'd0;
            score    <= 8'd0;
            miss_cnt <= 8'd0;
            hit      <= 1'b0;
            miss     <= 1'b0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            hit  <= hit_d;
            miss <= miss_d;
            if (pos_en) pos <= pick_pos(lfsr[1:0], pos);
            if (clear) begin
                score    <= 8'd0;
                miss_cnt <= 8'd0;
            end else begin
                if (hit_d && (score != 8'hFF)) score <= score + 8'd1;
                if (miss_d) miss_cnt <= miss_cnt_inc[7:0];
            end
        end
    end

endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer: table of press scenarios plus hand-written
// sequences for game over, score saturation and reset behaviour.
module tb_mole_sequencer;

    logic       clk_in = 1'b0;
    logic       rst_n = 1'b0;
    logic       slow_clk = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = 4'b0;
    logic [3:0] mole;
    logic       hit, miss, game_over;
    logic [7:0] score;

    int total = 0;
    int bad = 0;

    mole_sequencer dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .slow_clk  (slow_clk),
        .start     (start),
        .btn       (btn),
        .mole      (mole),
        .hit       (hit),
        .miss      (miss),
        .score     (score),
        .game_over (game_over)
    );

    always #5 clk_in = ~clk_in;

    // Reference LFSR; m_prev holds the value the DUT used at the most recent edge
    logic [7:0] m_lfsr, m_prev;
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_lfsr <= 8'hA5;
            m_prev <= 8'hA5;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        end
    end

    function automatic logic [3:0] oh(input logic [1:0] p);
        logic [3:0] r;
        r = 4'b0;
        r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] next_pos(input logic [7:0] l, input logic [1:0] prev);
        logic [1:0] r;
        r = l[1:0];
        if (r == prev) r = r + 2'd1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Drive buttons (and optionally a slow_clk transition), then run to the update edge
    task automatic apply(input logic [3:0] b, input logic tog);
        btn = b;
        if (tog) slow_clk = ~slow_clk;
        repeat (4) step();
    endtask

    task automatic release_flush();
        btn = 4'b0;
        repeat (4) step();
    endtask

    typedef struct {
        string      name;
        int         kind;
        logic       beat;
        logic       exp_hit;
        logic       exp_miss;
        logic       exp_show;
        logic [7:0] dscore;
    } vec_t;

    vec_t       tbl[6];
    logic [1:0] exp_pos;
    logic [1:0] old_pos;
    logic [7:0] exp_score;
    logic [3:0] b;
    logic       in_show;
    int         errs;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{"correct",      0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        tbl[1] = '{"lit_plus_one", 1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[2] = '{"wrong_single", 2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{"beat_no_press",3, 1'b1, 1'b0, 1'b1, 1'b1, 8'd0};
        tbl[4] = '{"hit_with_beat",0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[5] = '{"correct_again",0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        exp_pos = 2'd0;
        exp_score = 8'd0;

        repeat (3) step();
        chk("rst_mole", mole, 0);
        chk("rst_hit", hit, 0);
        chk("rst_miss", miss, 0);
        chk("rst_score", score, 0);
        chk("rst_game_over", game_over, 0);
        rst_n = 1'b1;
        step();

        start = 1'b1;
        step();
        start = 1'b0;
        chk("armed_mole", mole, 0);
        chk("armed_game_over", game_over, 0);

        slow_clk = ~slow_clk;
        repeat (3) step();
        chk("beat_not_early", mole, 0);
        step();
        exp_pos = next_pos(m_prev, exp_pos);
        chk("first_show", mole, oh(exp_pos));
        in_show = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (!in_show) begin
                apply(4'b0, 1'b1);
                exp_pos = next_pos(m_prev, exp_pos);
                chk({tbl[i].name, "_to_show"}, mole, oh(exp_pos));
            end
            case (tbl[i].kind)
                0:       b = oh(exp_pos);
                1:       b = oh(exp_pos) | oh(exp_pos + 2'd2);
                2:       b = oh(exp_pos + 2'd1);
                default: b = 4'b0;
            endcase
            old_pos = exp_pos;
            apply(b, tbl[i].beat);
            chk({tbl[i].name, "_hit"}, hit, tbl[i].exp_hit);
            chk({tbl[i].name, "_miss"}, miss, tbl[i].exp_miss);
            if (tbl[i].exp_show) begin
                exp_pos = next_pos(m_prev, exp_pos);
                chk({tbl[i].name, "_mole"}, mole, oh(exp_pos));
                chk({tbl[i].name, "_moved"}, (mole !== oh(old_pos)), 1);
            end else begin
                chk({tbl[i].name, "_mole"}, mole, 0);
            end
            exp_score = exp_score + tbl[i].dscore;
            chk({tbl[i].name, "_score"}, score, exp_score);
            in_show = tbl[i].exp_show;
            btn = 4'b0;
            step();
            chk({tbl[i].name, "_pulse_width"}, {hit, miss}, 0);
            repeat (3) step();
        end

        // Presses while cooling down are ignored
        apply(oh(exp_pos), 1'b0);
        chk("cool_press_hit", hit, 0);
        chk("cool_press_miss", miss, 0);
        chk("cool_press_mole", mole, 0);
        release_flush();

        // Three misses so far; two more end the game with score held
        apply(4'b0, 1'b1);
        exp_pos = next_pos(m_prev, exp_pos);
        chk("cool_beat_show", mole, oh(exp_pos));
        chk("cool_beat_no_miss", miss, 0);
        apply(4'b0, 1'b1);
        exp_pos = next_pos(m_prev, exp_pos);
        chk("miss4", miss, 1);
        chk("miss4_not_over", game_over, 0);
        apply(4'b0, 1'b1);
        chk("miss5", miss, 1);
        chk("over_game_over", game_over, 1);
        chk("over_mole", mole, 4'hF);
        chk("over_score_held", score, exp_score);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_mole", mole, 0);
        chk("restart_game_over", game_over, 0);
        chk("restart_score", score, 0);

        // Fresh game: five unanswered beats
        apply(4'b0, 1'b1);
        exp_pos = next_pos(m_prev, exp_pos);
        chk("g2_show", mole, oh(exp_pos));
        for (int k = 0; k < 5; k++) begin
            apply(4'b0, 1'b1);
            chk($sformatf("g2_miss%0d", k), miss, 1);
            if (k < 4) begin
                exp_pos = next_pos(m_prev, exp_pos);
                chk($sformatf("g2_mole%0d", k), mole, oh(exp_pos));
            end else begin
                chk("g2_over", game_over, 1);
                chk("g2_over_mole", mole, 4'hF);
                chk("g2_over_score", score, 0);
            end
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("g3_armed_mole", mole, 0);
        chk("g3_score", score, 0);

        // Saturation: keep the round alive with press+beat hits
        apply(4'b0, 1'b1);
        exp_pos = next_pos(m_prev, exp_pos);
        chk("g3_show", mole, oh(exp_pos));
        errs = 0;
        for (int k = 0; k < 255; k++) begin
            apply(oh(exp_pos), 1'b1);
            if (hit !== 1'b1) errs++;
            exp_pos = next_pos(m_prev, exp_pos);
            if (mole !== oh(exp_pos)) errs++;
            release_flush();
        end
        chk("preload_errors", errs, 0);
        chk("preload_score", score, 255);
        apply(oh(exp_pos), 1'b1);
        exp_pos = next_pos(m_prev, exp_pos);
        chk("sat_hit_pulse", hit, 1);
        chk("sat_score", score, 255);
        chk("sat_mole", mole, oh(exp_pos));
        btn = 4'b0;
        repeat (2) step();

        // Asynchronous reset while a correct press is in the synchronizer
        btn = oh(exp_pos);
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        chk("midrst_mole", mole, 0);
        chk("midrst_hit", hit, 0);
        chk("midrst_miss", miss, 0);
        chk("midrst_score", score, 0);
        chk("midrst_game_over", game_over, 0);
        btn = 4'b0;
        exp_pos = 2'd0;
        repeat (2) step();
        rst_n = 1'b1;
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (hit !== 1'b0 || miss !== 1'b0) errs++;
        end
        chk("post_rst_no_pulse", errs, 0);

        // slow_clk already high at reset release yields one beat
        rst_n = 1'b0;
        slow_clk = 1'b1;
        step();
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        chk("high_release_not_early", mole, 0);
        step();
        exp_pos = next_pos(m_prev, exp_pos);
        chk("high_release_beat", mole, oh(exp_pos));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mole_sequencer.md
MOLE_SEQUENCER -- requirements
Module: mole_sequencer

Interface
REQ-001 Parameter N_MOLES, default 4, number of mole LEDs/buttons (fixed at 4 this revision).
REQ-002 Parameter MAX_MISS, default 5, misses that end a game (range 1..255).
REQ-003 Parameter LFSR_SEED, default 8'hA5, LFSR reset value (nonzero).
REQ-004 clk_in  input  1  system clock, single clock domain.
REQ-005 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 slow_clk  input  1  divided blink clock from the led divider; asynchronous to clk_in; each transition is one beat.
REQ-007 start  input  1  synchronous level; starts a game when sampled high.
REQ-008 btn  input  4  raw player buttons, asynchronous, active-high.
REQ-009 mole  output  4  one-hot mole LED drive.
REQ-010 hit  output  1  one-cycle pulse per scored hit.
REQ-011 miss  output  1  one-cycle pulse per miss.
REQ-012 score  output  8  hit count, saturating.
REQ-013 game_over  output  1  high while in OVER.

Function
REQ-014 slow_clk passes a 2-flop synchronizer plus a delay flop; beat is a 1-cycle pulse on either edge of the synchronized level.
REQ-015 Each btn bit uses the same synchronizer; press is a 1-cycle pulse on its rising edge only.
REQ-016 Latency: beat/press pulse is high in the 3rd cycle after the first clk_in edge that samples the new input level; the resulting mole/hit/miss update is registered on the following edge.
REQ-017 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clk_in cycle in all states, never reaches zero.
REQ-018 New mole position = lfsr[1:0]; if equal to the previous position, use (lfsr[1:0]+1) mod 4.
REQ-019 States: IDLE, ARMED, SHOW, COOL, OVER.
REQ-020 IDLE: mole=0; start -> ARMED, score and miss counter cleared.
REQ-021 ARMED: mole=0; beat -> SHOW with new position.
REQ-022 SHOW: exactly one press and it matches mole -> hit pulse, score+1, COOL (mole=0).
REQ-023 SHOW: any press pattern other than exactly the lit button (wrong or multiple) -> miss pulse, COOL.
REQ-024 SHOW: beat with no press -> miss pulse, stay SHOW with new position.
REQ-025 SHOW: correct press and beat in same cycle -> hit counted, stay SHOW with new position.
REQ-026 COOL: beat -> SHOW with new position; presses ignored.
REQ-027 Miss counter (8-bit) increments per miss; reaching MAX_MISS -> OVER in the same transition, overriding SHOW/COOL.
REQ-028 OVER: mole=4'b1111, game_over=1, score held; start -> ARMED with counters cleared.
REQ-029 score saturates at 255; further hits still pulse hit.
REQ-030 start while in ARMED/SHOW/COOL is ignored.

Reset
REQ-031 rst_n low: state=IDLE, mole=0, hit=0, miss=0, score=0, game_over=0, miss counter=0, lfsr=LFSR_SEED, all synchronizer flops 0.
REQ-032 Reset mid-game aborts immediately; no hit/miss pulse is emitted on release.
REQ-033 After rst_n release, a slow_clk already high produces one beat (sync flops start at 0); this is required behaviour.

Structure
REQ-034 Shared package whack_pkg holds state encodings, N_MOLES, MAX_MISS default, LFSR taps and seed.
REQ-035 One sub-module sync_edge (2-flop sync, delay flop, rise/fall/any-edge pulse outputs), instantiated once for slow_clk and four times for btn.

Verification
REQ-036 Reset, start=1 one cycle, toggle slow_clk -> SHOW with mole one-hot exactly 4 edges after sampling; value matches model LFSR.
REQ-037 In SHOW press the lit button -> hit 1 cycle, score 0->1, mole=0 until next beat.
REQ-038 In SHOW press lit+one other button together -> miss pulse, score unchanged, COOL.
REQ-039 Let 5 beats pass without presses -> 5 miss pulses, game_over=1, mole=4'b1111; start -> ARMED, score=0.
REQ-040 Correct press and beat coincident at pulse level -> hit pulse, score+1, new mole differing from previous position.
REQ-041 Preload 255 hits via repeated stimulus -> score stays 255 on 256th hit, hit still pulses; assert rst_n mid-SHOW -> all outputs 0 within the reset cycle.
